// File: rtl/mc_phy_model.sv
// ---------------------------------------------------------------------------
// mc_phy_model
//
// Cycle-level DDR3 PHY behavioural model that closes the MC<->PHY loop around
// the memory controller in simulation. Each PHY cycle carries NUM_SLOTS
// command slots. The model tracks per-bank open/row state, keeps write data
// in a byte-maskable backing store, and returns read data after a fixed
// latency. It also raises calibration-complete and sticky protocol error
// flags.
//
// Ports
//   clk, rst_n            PHY clock (rising edge), async active-low reset
//   mc_cmd_wren           command slots valid this cycle
//   mc_ras_n/cas_n/we_n   per-slot command bits
//   mc_cs_n               per-slot chip select (1 = NOP slot)
//   mc_address            per-slot row (ACT) or column (RD/WR)
//   mc_bank               per-slot bank
//   mc_wrdata_en          write data valid, same cycle as the WR slot
//   mc_wrdata             write data
//   mc_wrdata_mask        byte mask, 1 = byte not written
//   phy_mc_cmd_full       command back-pressure (outstanding reads)
//   phy_mc_ctl_full       copy of phy_mc_cmd_full
//   phy_mc_data_full      tied to 0
//   calib_rd_data_offset  RD_OFFSET once calibrated, else 0
//   init_calib_complete   calibration done, sticky until reset
//   phy_rddata_valid      read data valid
//   phy_rd_data           read data
//   err_flags             sticky: [0] RD/WR to closed bank, [1] ACT to open
//                         bank, [2] >1 CAS in one cycle, [3] command while full
//
// Handshake: phy_mc_cmd_full is advisory back-pressure. The controller should
// hold off commands while it is high; a command presented anyway is still
// executed and sets err_flags[3]. Read data has no ready: phy_rddata_valid is a
// one-cycle pulse per read and must be taken when it is high.
// ---------------------------------------------------------------------------
module mc_phy_model #(
    parameter int          NUM_SLOTS    = 4,
    parameter int          ROW_SZ       = 16,
    parameter int          BANK_SZ      = 3,
    parameter int          DATA_W       = 512,
    parameter int          RD_LATENCY   = 8,
    parameter int          MAX_RD_OUT   = 6,
    parameter int          MEM_AW       = 10,
    parameter int          CALIB_CYCLES = 64,
    parameter logic [5:0]  RD_OFFSET    = 6'd9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mc_cmd_wren,
    input  logic [NUM_SLOTS-1:0]          mc_ras_n,
    input  logic [NUM_SLOTS-1:0]          mc_cas_n,
    input  logic [NUM_SLOTS-1:0]          mc_we_n,
    input  logic [NUM_SLOTS-1:0]          mc_cs_n,
    input  logic [NUM_SLOTS*ROW_SZ-1:0]   mc_address,
    input  logic [NUM_SLOTS*BANK_SZ-1:0]  mc_bank,
    input  logic                          mc_wrdata_en,
    input  logic [DATA_W-1:0]             mc_wrdata,
    input  logic [DATA_W/8-1:0]           mc_wrdata_mask,
    output logic                          phy_mc_cmd_full,
    output logic                          phy_mc_ctl_full,
    output logic                          phy_mc_data_full,
    output logic [5:0]                    calib_rd_data_offset,
    output logic                          init_calib_complete,
    output logic                          phy_rddata_valid,
    output logic [DATA_W-1:0]             phy_rd_data,
    output logic [3:0]                    err_flags
);

    localparam int NUM_BANKS = 1 << BANK_SZ;
    localparam int COL_W     = MEM_AW - BANK_SZ;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int CNT_W     = $clog2(RD_LATENCY + 1);
    localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);

    // Backing store: zero at time 0 only, deliberately untouched by reset so
    // data survives a controller reset inside one simulation.
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1] = '{default: '0};

    // Bank state
    logic [NUM_BANKS-1:0]             open_q, open_d;
    logic [NUM_BANKS-1:0][ROW_SZ-1:0] row_q, row_d;
    logic [3:0]                       err_q, err_d;

    // Per-cycle decode results
    logic               cas_seen;
    logic               cas_is_wr;
    logic [BANK_SZ-1:0] cas_bank;
    logic [COL_W-1:0]   cas_col;
    logic               any_cmd;
    logic [BANK_SZ-1:0] slot_bank;
    logic [ROW_SZ-1:0]  slot_addr;

    // Read pipe
    logic [RD_LATENCY-1:0] pv_q;
    logic [MEM_AW-1:0]     pidx_q [RD_LATENCY];
    logic [CNT_W-1:0]      rd_out_q, rd_out_d;
    logic                  full_q;
    logic                  rd_capture;
    logic                  rd_exit;
    logic                  wr_do;
    logic [MEM_AW-1:0]     cas_idx;

    // Calibration
    logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
    logic             calib_q;

    logic              rddata_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Slots are walked in order so an ACT/PRE in a lower slot is seen by a
    // RD/WR in a higher slot of the same cycle. Only the first CAS executes.
    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        err_d     = err_q;
        cas_seen  = 1'b0;
        cas_is_wr = 1'b0;
        cas_bank  = '0;
        cas_col   = '0;
        any_cmd   = 1'b0;
        slot_bank = '0;
        slot_addr = '0;
        if (mc_cmd_wren) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_bank = mc_bank[s*BANK_SZ +: BANK_SZ];
                slot_addr = mc_address[s*ROW_SZ +: ROW_SZ];
                if (!mc_cs_n[s]) begin
                    case ({mc_ras_n[s], mc_cas_n[s], mc_we_n[s]})
                        3'b011: begin // ACT
                            any_cmd = 1'b1;
                            if (open_d[slot_bank]) err_d[1] = 1'b1;
                            open_d[slot_bank] = 1'b1;
                            row_d[slot_bank]  = slot_addr;
                        end
                        3'b101, 3'b100: begin // RD, WR
                            any_cmd = 1'b1;
                            if (cas_seen) begin
                                err_d[2] = 1'b1;
                            end else begin
                                cas_seen  = 1'b1;
                                cas_is_wr = !mc_we_n[s];
                                cas_bank  = slot_bank;
                                cas_col   = slot_addr[COL_W-1:0];
                                if (!open_d[slot_bank]) err_d[0] = 1'b1;
                            end
                        end
                        3'b010: begin // PRE, A10 selects all banks
                            any_cmd = 1'b1;
                            if (slot_addr[10]) open_d = '0;
                            else               open_d[slot_bank] = 1'b0;
                        end
                        3'b001: any_cmd = 1'b1; // REF
                        default: ;
                    endcase
                end
            end
        end
        if (any_cmd && full_q) err_d[3] = 1'b1;
    end

    assign cas_idx    = {cas_bank, cas_col};
    assign rd_capture = cas_seen && !cas_is_wr;
    assign wr_do      = cas_seen && cas_is_wr && mc_wrdata_en;
    assign rd_exit    = pv_q[RD_LATENCY-1];

    always_comb begin
        rd_out_d = rd_out_q;
        if (rd_capture && !rd_exit)      rd_out_d = rd_out_q + CNT_W'(1);
        else if (!rd_capture && rd_exit) rd_out_d = rd_out_q - CNT_W'(1);
    end

    always_comb begin
        cal_cnt_d = cal_cnt_q;
        if (cal_cnt_q != CAL_W'(CALIB_CYCLES)) cal_cnt_d = cal_cnt_q + CAL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q         <= '0;
            row_q          <= '0;
            err_q          <= '0;
            pv_q           <= '0;
            rd_out_q       <= '0;
            full_q         <= 1'b0;
            cal_cnt_q      <= '0;
            calib_q        <= 1'b0;
            rddata_valid_q <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            open_q         <= open_d;
            row_q          <= row_d;
            err_q          <= err_d;
            pv_q           <= {pv_q[RD_LATENCY-2:0], rd_capture};
            rd_out_q       <= rd_out_d;
            full_q         <= (rd_out_d >= CNT_W'(MAX_RD_OUT));
            cal_cnt_q      <= cal_cnt_d;
            calib_q        <= (cal_cnt_d == CAL_W'(CALIB_CYCLES));
            rddata_valid_q <= rd_exit;
            // Store is read at pipe exit so writes issued while the read is
            // in flight are returned.
            if (rd_exit) rd_data_q <= mem[pidx_q[RD_LATENCY-1]];
        end
    end

    // Index pipe only carries payload; validity lives in pv_q.
    always_ff @(posedge clk) begin
        pidx_q[0] <= cas_idx;
        for (int i = 1; i < RD_LATENCY; i++) pidx_q[i] <= pidx_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (wr_do) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (!mc_wrdata_mask[b]) mem[cas_idx][b*8 +: 8] <= mc_wrdata[b*8 +: 8];
            end
        end
    end

    // Row is tracked for completeness of bank state but nothing consumes it.
    logic unused_row;
    assign unused_row = ^row_q;

    assign phy_mc_cmd_full      = full_q;
    assign phy_mc_ctl_full      = full_q;
    assign phy_mc_data_full     = 1'b0;
    assign init_calib_complete  = calib_q;
    assign calib_rd_data_offset = calib_q ? RD_OFFSET : 6'd0;
    assign phy_rddata_valid     = rddata_valid_q;
    assign phy_rd_data          = rd_data_q;
    assign err_flags            = err_q;

endmodule

// File: tb/tb_mc_phy_model.sv
module tb_mc_phy_model;

    localparam int NUM_SLOTS  = 4;
    localparam int ROW_SZ     = 16;
    localparam int BANK_SZ    = 3;
    localparam int DATA_W     = 512;
    localparam int RD_LATENCY = 8;
    localparam int MEM_AW     = 10;
    localparam int COL_W      = MEM_AW - BANK_SZ;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_REF = 3'b001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                         mc_cmd_wren;
    logic [NUM_SLOTS-1:0]         mc_ras_n, mc_cas_n, mc_we_n, mc_cs_n;
    logic [NUM_SLOTS*ROW_SZ-1:0]  mc_address;
    logic [NUM_SLOTS*BANK_SZ-1:0] mc_bank;
    logic                         mc_wrdata_en;
    logic [DATA_W-1:0]            mc_wrdata;
    logic [DATA_W/8-1:0]          mc_wrdata_mask;
    logic                         phy_mc_cmd_full, phy_mc_ctl_full, phy_mc_data_full;
    logic [5:0]                   calib_rd_data_offset;
    logic                         init_calib_complete;
    logic                         phy_rddata_valid;
    logic [DATA_W-1:0]            phy_rd_data;
    logic [3:0]                   err_flags;

    mc_phy_model dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mc_cmd_wren          (mc_cmd_wren),
        .mc_ras_n             (mc_ras_n),
        .mc_cas_n             (mc_cas_n),
        .mc_we_n              (mc_we_n),
        .mc_cs_n              (mc_cs_n),
        .mc_address           (mc_address),
        .mc_bank              (mc_bank),
        .mc_wrdata_en         (mc_wrdata_en),
        .mc_wrdata            (mc_wrdata),
        .mc_wrdata_mask       (mc_wrdata_mask),
        .phy_mc_cmd_full      (phy_mc_cmd_full),
        .phy_mc_ctl_full      (phy_mc_ctl_full),
        .phy_mc_data_full     (phy_mc_data_full),
        .calib_rd_data_offset (calib_rd_data_offset),
        .init_calib_complete  (init_calib_complete),
        .phy_rddata_valid     (phy_rddata_valid),
        .phy_rd_data          (phy_rd_data),
        .err_flags            (err_flags)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    int                exp_cyc_q[$];
    logic [DATA_W-1:0] model_mem [0:(1<<MEM_AW)-1];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read data monitor: pops the expected queue on every valid pulse.
    always @(negedge clk) begin
        if (rst_n && phy_rddata_valid) begin
            check("rd_pending", 512'(exp_q.size() != 0), 512'(1));
            if (exp_q.size() != 0) begin
                check("rd_data", phy_rd_data, exp_q.pop_front());
                check("rd_latency", 512'(cyc), 512'(exp_cyc_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [MEM_AW-1:0] idx_of(input logic [2:0] bank, input logic [15:0] col);
        return {bank, col[COL_W-1:0]};
    endfunction

    task automatic clear_bus();
        mc_cmd_wren    = 1'b0;
        mc_ras_n       = '1;
        mc_cas_n       = '1;
        mc_we_n        = '1;
        mc_cs_n        = '1;
        mc_address     = '0;
        mc_bank        = '0;
        mc_wrdata_en   = 1'b0;
        mc_wrdata      = '0;
        mc_wrdata_mask = '0;
    endtask

    task automatic set_slot(input int s, input logic [2:0] rcw, input logic [2:0] bank, input logic [15:0] addr);
        mc_cmd_wren = 1'b1;
        mc_cs_n[s]  = 1'b0;
        mc_ras_n[s] = rcw[2];
        mc_cas_n[s] = rcw[1];
        mc_we_n[s]  = rcw[0];
        mc_address[s*ROW_SZ +: ROW_SZ] = addr;
        mc_bank[s*BANK_SZ +: BANK_SZ]  = bank;
    endtask

    task automatic tick();
        @(negedge clk);
        clear_bus();
    endtask

    task automatic model_write(input logic [MEM_AW-1:0] idx, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] m);
        for (int b = 0; b < DATA_W/8; b++)
            if (!m[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic do_act(input logic [2:0] bank, input logic [15:0] row);
        set_slot(0, C_ACT, bank, row);
        tick();
    endtask

    task automatic do_ref();
        set_slot(0, C_REF, 3'd0, 16'd0);
        tick();
    endtask

    task automatic do_wr(input logic [2:0] bank, input logic [15:0] col, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] m);
        set_slot(0, C_WR, bank, col);
        mc_wrdata_en   = 1'b1;
        mc_wrdata      = d;
        mc_wrdata_mask = m;
        model_write(idx_of(bank, col), d, m);
        tick();
    endtask

    task automatic push_rd(input logic [2:0] bank, input logic [15:0] col);
        exp_q.push_back(model_mem[idx_of(bank, col)]);
        exp_cyc_q.push_back(cyc + 1 + RD_LATENCY);
    endtask

    task automatic do_rd(input logic [2:0] bank, input logic [15:0] col);
        set_slot(0, C_RD, bank, col);
        push_rd(bank, col);
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 512'(exp_q.size()), 512'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < (1<<MEM_AW); i++) model_mem[i] = '0;
        clear_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid", 512'(phy_rddata_valid), 512'(0));
        check("rst_err", 512'(err_flags), 512'(0));
        check("rst_full", 512'(phy_mc_cmd_full), 512'(0));
        check("rst_calib", 512'(init_calib_complete), 512'(0));
        check("rst_rd_data", phy_rd_data, 512'(0));

        // Calibration: low for 63 cycles, high on cycle 64
        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check($sformatf("calib_c%0d", k), 512'(init_calib_complete), 512'(k == 64));
            if (k == 63) check("offset_precal", 512'(calib_rd_data_offset), 512'(0));
        end
        check("offset_cal", 512'(calib_rd_data_offset), 512'(6'd9));
        check("data_full", 512'(phy_mc_data_full), 512'(0));

        // Basic write/read
        do_act(3'd2, 16'd5);
        do_wr(3'd2, 16'd8, {64{8'hA5}}, '0);
        do_rd(3'd2, 16'd8);
        drain();

        // Masked write: byte 0 keeps old data
        do_wr(3'd2, 16'd8, {64{8'h5A}}, 64'h1);
        do_rd(3'd2, 16'd8);
        drain();

        // Back-pressure with six reads
        for (int i = 0; i < 6; i++) begin
            do_rd(3'd2, 16'(8 + i));
            check($sformatf("cmd_full_rd%0d", i), 512'(phy_mc_cmd_full), 512'(i == 5));
            check($sformatf("ctl_full_rd%0d", i), 512'(phy_mc_ctl_full), 512'(i == 5));
        end
        tick(); check("full_hold1", 512'(phy_mc_cmd_full), 512'(1));
        tick(); check("full_hold2", 512'(phy_mc_cmd_full), 512'(1));
        tick(); check("full_drop", 512'(phy_mc_cmd_full), 512'(0));
        drain();
        check("full_idle", 512'(phy_mc_cmd_full), 512'(0));
        check("err_clean", 512'(err_flags), 512'(0));

        // Error flags
        do_rd(3'd5, 16'd3);
        check("err_closed", 512'(err_flags), 512'(4'b0001));
        do_act(3'd1, 16'd7);
        do_act(3'd1, 16'd9);
        check("err_act_open", 512'(err_flags), 512'(4'b0011));
        // RD in slot 0 and WR in slot 1: only the read executes
        set_slot(0, C_RD, 3'd2, 16'd20);
        set_slot(1, C_WR, 3'd2, 16'd20);
        mc_wrdata_en = 1'b1;
        mc_wrdata    = {64{8'hFF}};
        push_rd(3'd2, 16'd20);
        tick();
        check("err_multi_cas", 512'(err_flags), 512'(4'b0111));
        drain();
        do_rd(3'd2, 16'd20);
        drain();
        // Command while full
        for (int i = 0; i < 6; i++) do_rd(3'd2, 16'd8);
        do_ref();
        check("err_cmd_full", 512'(err_flags), 512'(4'b1111));
        drain();

        // Reset with reads in flight
        do_rd(3'd2, 16'd8);
        do_rd(3'd2, 16'd9);
        do_rd(3'd2, 16'd10);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check("midrst_err", 512'(err_flags), 512'(0));
        check("midrst_valid", 512'(phy_rddata_valid), 512'(0));
        check("midrst_calib", 512'(init_calib_complete), 512'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
        check("post_rst_err", 512'(err_flags), 512'(0));
        check("post_rst_full", 512'(phy_mc_cmd_full), 512'(0));
        check("post_rst_calib", 512'(init_calib_complete), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
